inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction fetch stage for the single-cycle RISC-V core. It holds the program counter, runs a request/acknowledge handshake with instruction memory, and registers the fetched word. It also pre-decodes the opcode into the 3-bit `imm_type` code consumed by the immediate generator. It presents one instruction at a time to decode/execute and advances only when the core retires that instruction.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `imem_req`  out  1  fetch request to instruction memory; held until acknowledged.
- `imem_addr`  out  32  fetch address; equals `pc` whenever `imem_req`=1.
- `imem_ack`  in  1  memory acknowledge; `imem_rdata` is valid in the same cycle.
- `imem_rdata`  in  32  instruction word.
- `inst_valid`  out  1  `inst`/`pc`/`imm_type` hold a fetched instruction.
- `inst`  out  32  registered instruction; goes to decode and to the immediate generator `inst`.
- `imm_type`  out  3  registered immediate class; goes to the immediate generator `imm_type`.
- `pc`  out  32  address of the current instruction.
- `pc_plus4`  out  32  `pc + 4`, modulo 2^32.
- `inst_done`  in  1  core retires the current instruction.
- `pc_sel`  in  1  with `inst_done`: 1 = take `target`, 0 = sequential.
- `target`  in  32  branch/jump target.
- `misaligned`  out  1  sticky fetch-address-misaligned flag.

## Operation
- FSM states: BOOT, FETCH, HOLD, HALT.
- Reset: state=BOOT, `pc`=`RESET_PC`, `inst`=32'h0000_0013 (NOP), `imm_type`=3'b000, `inst_valid`=0, `misaligned`=0. `imem_req` is 0 during reset.
- BOOT: `imem_req`=0 for exactly one cycle, then FETCH. This guarantees a request never overlaps a response abandoned by reset.
- FETCH: `imem_req`=1, `imem_addr`=`pc`. When `imem_ack`=1: capture `imem_rdata` into `inst`, set `imm_type`, set `inst_valid`=1, go to HOLD.
- HOLD: `imem_req`=0 and `inst_valid`=1 until `inst_done`. On `inst_done`:
  - `pc_sel`=0: `pc`←`pc_plus4`, `inst_valid`←0, go to FETCH.
  - `pc_sel`=1 and `target[1:0]`=0: `pc`←`target`, `inst_valid`←0, go to FETCH.
  - `pc_sel`=1 and `target[1:0]`≠0: `pc` unchanged, `misaligned`←1, `inst_valid`←0, go to HALT.
- HALT: no requests, `inst_valid`=0. Only `rst` exits HALT.
- `imm_type` decode from `imem_rdata[6:0]`:
  - 0010011, 0000011, 1100111 → 000 (I)
  - 0100011 → 001 (S)
  - 1101111 → 010 (J)
  - 1100011 → 011 (B)
  - 0110111, 0010111 → 100 (U)
  - any other opcode → 111 (no immediate)
- Ignored inputs: `imem_ack` outside FETCH (including BOOT and HALT); `inst_done` outside HOLD; `pc_sel`/`target` without `inst_done`.
- Arithmetic: `pc_plus4` is a 32-bit add with wrap; 32'hFFFF_FFFC → 32'h0000_0000. `pc[1:0]` is always 0.

## Timing
- Fetch latency: `inst_valid` rises on the cycle after `imem_ack`. With zero wait states, `imem_req` is high for 1 cycle and `inst_valid` is high the next cycle.
- `imem_req` drops in the cycle after `imem_ack`, and `imem_addr` is stable while `imem_req`=1.
- `inst_done` may arrive in the first `inst_valid` cycle. In that case `imem_req` rises the next cycle with the new `pc`.
- Best-case throughput is one instruction every 2 cycles.
- First request after `rst` deasserts: cycle 0 is BOOT (`imem_req`=0), `imem_req` rises in cycle 1.
- `rst` in any state, including mid-FETCH with `imem_req` high, takes effect at the next edge: all outputs return to reset values and the outstanding request is abandoned.

## Test plan
- Reset with `RESET_PC`=0, memory with zero wait → `imem_req` low 1 cycle after reset, then high with `imem_addr`=0. `inst_valid`=1 the next cycle with `inst`=`imem_rdata`.
- 3 wait-state memory → `imem_req` and `imem_addr` held 4 cycles. `inst_valid` rises 1 cycle after ack.
- Feed 0x00500093, 0x00112623, 0x008000EF, 0x00208463, 0x123450B7, 0x002081B3 sequentially, retiring each with `pc_sel`=0:
  - `imm_type` = 000, 001, 010, 011, 100, 111 respectively.
  - `pc` = 0x0, 0x4, …, 0x14.
- `inst_done` with `pc_sel`=1 and `target`=0x100 → next `imem_addr`=0x100. Then `target`=0x102 → `misaligned`=1 and no further `imem_req` until reset.
- `RESET_PC`=32'hFFFF_FFFC → `pc_plus4`=0, and the sequential retire fetches address 0.
- Assert `rst` mid-wait, then ack 1 cycle after `rst` deasserts → ack ignored (BOOT). The new request is issued with `imem_addr`=`RESET_PC` and `inst_valid` stays 0 until the new ack.

Source files
------------

// File: rtl/inst_fetch.sv
// inst_fetch: program counter, imem request/ack handshake, instruction register
// and imm_type pre-decode; presents one instruction until the core retires it.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [2:0]  imm_type,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        inst_done,
  input  logic        pc_sel,
  input  logic [31:0] target,
  output logic        misaligned
);
  typedef enum logic [1:0] {BOOT, FETCH, HOLD, HALT} state_t;
  state_t state, state_n;
  logic [31:0] pc_n, inst_n;
  logic [2:0] imm_n, dec;
  logic mis_n;
  logic [6:0] op;
  assign op = imem_rdata[6:0];
  assign dec = (op == 7'b0010011 || op == 7'b0000011 || op == 7'b1100111) ? 3'b000 :
               (op == 7'b0100011) ? 3'b001 :
               (op == 7'b1101111) ? 3'b010 :
               (op == 7'b1100011) ? 3'b011 :
               (op == 7'b0110111 || op == 7'b0010111) ? 3'b100 : 3'b111;
  assign imem_req   = state == FETCH;
  assign imem_addr  = pc;
  assign inst_valid = state == HOLD;
  assign pc_plus4   = pc + 32'd4;
  always_comb begin
    state_n = state;
    pc_n    = pc;
    inst_n  = inst;
    imm_n   = imm_type;
    mis_n   = misaligned;
    if (state == BOOT) state_n = FETCH;
    else if (state == FETCH && imem_ack) begin
      state_n = HOLD;
      inst_n  = imem_rdata;
      imm_n   = dec;
    end else if (state == HOLD && inst_done) begin
      // a misaligned jump target freezes the stage with pc still on the jump
      if (pc_sel && target[1:0] != 2'b00) begin
        state_n = HALT;
        mis_n   = 1'b1;
      end else begin
        state_n = FETCH;
        pc_n    = pc_sel ? target : pc_plus4;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= BOOT;
      pc         <= RESET_PC;
      inst       <= 32'h0000_0013;
      imm_type   <= 3'b000;
      misaligned <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      inst       <= inst_n;
      imm_type   <= imm_n;
      misaligned <= mis_n;
    end
  end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: randomized memory/core stimulus against a transaction-level
// model of the fetch stage, plus a second instance with RESET_PC at the top of memory.
module tb_inst_fetch;
  logic clk = 1'b0;
  logic rst;
  logic imem_req, imem_ack, inst_valid, inst_done, pc_sel, misaligned;
  logic [31:0] imem_addr, imem_rdata, inst, pc, pc_plus4, target;
  logic [2:0] imm_type;
  logic w_req, w_ack, w_valid, w_done, w_sel, w_mis;
  logic [31:0] w_addr, w_rdata, w_inst, w_pc, w_pc_plus4, w_target;
  logic [2:0] w_imm;
  int n_cmp = 0, n_err = 0;
  logic [31:0] mpc, minst;
  logic halted;
  always #5 clk = ~clk;
  inst_fetch dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
    .inst(inst), .imm_type(imm_type), .pc(pc), .pc_plus4(pc_plus4),
    .inst_done(inst_done), .pc_sel(pc_sel), .target(target), .misaligned(misaligned)
  );
  inst_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(w_ack), .imem_rdata(w_rdata), .inst_valid(w_valid),
    .inst(w_inst), .imm_type(w_imm), .pc(w_pc), .pc_plus4(w_pc_plus4),
    .inst_done(w_done), .pc_sel(w_sel), .target(w_target), .misaligned(w_mis)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [2:0] exp_imm(input logic [6:0] o);
    case (o)
      7'h13, 7'h03, 7'h67: return 3'd0;
      7'h23:               return 3'd1;
      7'h6F:               return 3'd2;
      7'h63:               return 3'd3;
      7'h37, 7'h17:        return 3'd4;
      default:             return 3'd7;
    endcase
  endfunction
  function automatic logic [31:0] rand_word();
    logic [6:0] ops [10] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h6F, 7'h63, 7'h37, 7'h17, 7'h33, 7'h73};
    logic [31:0] r;
    logic [6:0] o;
    r = $urandom;
    o = ($urandom_range(0, 4) == 0) ? r[6:0] : ops[$urandom_range(0, 9)];
    return {r[31:7], o};
  endfunction
  // reset, then the single BOOT cycle with a stray ack that must be ignored
  task automatic do_reset;
    rst = 1'b1; imem_ack = 1'b0; inst_done = 1'b0; pc_sel = 1'b0;
    tick; tick;
    rst = 1'b0;
    chk("rst_req", imem_req, 0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_pc", pc, 0);
    chk("rst_inst", inst, 32'h13);
    chk("rst_imm", imm_type, 0);
    chk("rst_mis", misaligned, 0);
    mpc = 32'h0;
    imem_ack = 1'b1; imem_rdata = $urandom;
    tick;
    imem_ack = 1'b0;
    chk("boot_valid", inst_valid, 0);
  endtask
  task automatic fetch(input int ws, input logic [31:0] w);
    for (int i = 0; i < ws; i++) begin
      imem_ack = 1'b0; inst_done = $urandom; pc_sel = $urandom; target = $urandom;
      chk("wait_req", imem_req, 1);
      chk("wait_addr", imem_addr, mpc);
      chk("wait_valid", inst_valid, 0);
      tick;
    end
    imem_ack = 1'b1; imem_rdata = w; inst_done = $urandom;
    chk("ack_req", imem_req, 1);
    chk("ack_addr", imem_addr, mpc);
    tick;
    imem_ack = 1'b0; imem_rdata = $urandom; inst_done = 1'b0;
    minst = w;
    chk("f_valid", inst_valid, 1);
    chk("f_inst", inst, w);
    chk("f_imm", imm_type, exp_imm(w[6:0]));
    chk("f_pc", pc, mpc);
    chk("f_pc4", pc_plus4, mpc + 32'd4);
    chk("f_req", imem_req, 0);
  endtask
  task automatic retire(input int hold, input logic sel, input logic [31:0] tgt,
                        output logic h);
    for (int i = 0; i < hold; i++) begin
      inst_done = 1'b0; pc_sel = $urandom; target = $urandom;
      imem_ack = $urandom; imem_rdata = $urandom;
      tick;
      chk("hold_valid", inst_valid, 1);
      chk("hold_inst", inst, minst);
      chk("hold_req", imem_req, 0);
    end
    inst_done = 1'b1; pc_sel = sel; target = tgt; imem_ack = 1'b0;
    tick;
    inst_done = 1'b0; pc_sel = 1'b0;
    h = sel && tgt[1:0] != 2'b00;
    if (!h) mpc = sel ? tgt : mpc + 32'd4;
    chk("ret_valid", inst_valid, 0);
    chk("ret_mis", misaligned, h);
    chk("ret_pc", pc, mpc);
  endtask
  task automatic halt_check;
    for (int i = 0; i < 5; i++) begin
      imem_ack = $urandom; inst_done = $urandom; pc_sel = 1'b1; target = $urandom;
      tick;
      chk("halt_req", imem_req, 0);
      chk("halt_valid", inst_valid, 0);
      chk("halt_mis", misaligned, 1);
      chk("halt_pc", pc, mpc);
    end
    imem_ack = 1'b0; inst_done = 1'b0;
  endtask
  initial begin
    logic [31:0] prog [6] = '{32'h00500093, 32'h00112623, 32'h008000EF,
                              32'h00208463, 32'h123450B7, 32'h002081B3};
    logic [2:0] imms [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
    logic [31:0] r;
    int k;
    w_ack = 1'b0; w_done = 1'b0; w_sel = 1'b0; w_target = 32'h0; w_rdata = 32'h0;
    imem_rdata = 32'h0; target = 32'h0;
    do_reset;
    for (int i = 0; i < 6; i++) begin
      fetch(i == 1 ? 3 : 0, prog[i]);
      chk("dir_imm", imm_type, imms[i]);
      chk("dir_pc", pc, i * 4);
      retire(i == 0 ? 0 : 1, 1'b0, 32'h0, halted);
    end
    fetch(0, rand_word());
    retire(0, 1'b1, 32'h100, halted);
    chk("jmp_addr", imem_addr, 32'h100);
    fetch(2, rand_word());
    retire(1, 1'b1, 32'h102, halted);
    chk("mis_flag", misaligned, 1);
    halt_check;
    do_reset;
    fetch(1, rand_word());
    retire(0, 1'b0, 32'h0, halted);
    imem_ack = 1'b0;
    tick; tick;
    chk("midwait_req", imem_req, 1);
    do_reset;
    chk("rewait_req", imem_req, 1);
    chk("rewait_addr", imem_addr, 32'h0);
    fetch(2, rand_word());
    retire(0, 1'b0, 32'h0, halted);
    for (int n = 0; n < 300; n++) begin
      fetch($urandom_range(0, 3), rand_word());
      k = $urandom_range(0, 15);
      r = $urandom;
      if (k == 0) retire($urandom_range(0, 2), 1'b1, {r[31:2], 2'b00} | 32'd1 << $urandom_range(0, 1), halted);
      else if (k == 1) retire($urandom_range(0, 2), 1'b1, 32'hFFFF_FFFC, halted);
      else if (k < 6) retire($urandom_range(0, 2), 1'b1, {r[31:2], 2'b00}, halted);
      else retire($urandom_range(0, 2), 1'b0, 32'h0, halted);
      if (halted) begin
        halt_check;
        do_reset;
      end
    end
    rst = 1'b1; imem_ack = 1'b0; inst_done = 1'b0;
    tick;
    rst = 1'b0;
    chk("w_rst_pc", w_pc, 32'hFFFF_FFFC);
    chk("w_pc4", w_pc_plus4, 32'h0);
    chk("w_boot_req", w_req, 0);
    tick;
    chk("w_req", w_req, 1);
    chk("w_addr", w_addr, 32'hFFFF_FFFC);
    w_ack = 1'b1; w_rdata = 32'h0000_0013;
    tick;
    w_ack = 1'b0;
    chk("w_valid", w_valid, 1);
    w_done = 1'b1;
    tick;
    w_done = 1'b0;
    chk("w_wrap_req", w_req, 1);
    chk("w_wrap_addr", w_addr, 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
